// File: rtl/mtm_alu_pkg.sv
// Shared types, error codes and CRC helper for the mtm_Alu command path.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b100,
    SUB = 3'b101,
    RST = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    DATA = 2'b00,
    CTL  = 2'b01,
    ERR  = 2'b10
  } byte_type_t;

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  // Remainder of ({B, A, 1'b1, op} * x^4) modulo x^4 + x + 1, state starting at 0.
  function automatic logic [3:0] crc4_calc(input logic [31:0] B,
                                           input logic [31:0] A,
                                           input logic [2:0]  op);
    logic [71:0] aug;
    logic [3:0]  crc;
    logic        fb;
    aug = {B, A, 1'b1, op, 4'b0000};
    crc = '0;
    for (int unsigned i = 0; i < 72; i++) begin
      fb  = crc[3];
      crc = {crc[2:0], aug[71]} ^ (fb ? 4'b0011 : 4'b0000);
      aug = aug << 1;
    end
    return crc;
  endfunction

endpackage

// File: rtl/mtm_alu_byte_rx.sv
// Bit-level receiver: recovers one 11-bit frame (start, type, d[7:0], stop).
module mtm_alu_byte_rx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       byte_valid,
  output byte_type_t byte_type,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_type;
  logic [7:0]  r_data;
  logic [2:0]  r_bit_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state; byte delivery and framing error are flagged while the stop bit is on the line.
  always_comb begin
    w_next     = r_state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    byte_type  = r_type ? CTL : DATA;
    byte_data  = r_data;
    case (r_state)
      S_IDLE:    if (!sin) w_next = S_TYPE;
      S_TYPE:    w_next = S_PAYLOAD;
      S_PAYLOAD: if (r_bit_cnt == 3'd7) w_next = S_STOP;
      S_STOP: begin
        w_next = S_IDLE;
        if (sin) begin
          byte_valid = 1'b1;
        end else begin
          frame_err = 1'b1;
          byte_type = ERR;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Type latch and MSB-first payload shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type    <= 1'b0;
      r_data    <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        S_TYPE: begin
          r_type    <= sin;
          r_bit_cnt <= '0;
        end
        S_PAYLOAD: begin
          r_data    <= {r_data[6:0], sin};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mtm_alu_cmd_deserializer.sv
// Command assembly: eight data bytes plus a control byte become (B, A, op) or an error report.
module mtm_alu_cmd_deserializer
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] B,
  output logic [31:0] A,
  output logic [2:0]  op,
  output logic [2:0]  err_flags
);

  logic        w_byte_valid;
  byte_type_t  w_byte_type;
  logic [7:0]  w_byte_data;
  logic        w_frame_err;

  logic [3:0]  r_byte_cnt;
  logic [63:0] r_shift;
  logic        r_cmd_valid;
  logic [31:0] r_B;
  logic [31:0] r_A;
  logic [2:0]  r_op;
  logic [2:0]  r_err;

  logic        w_crc_ok;
  logic        w_op_ok;
  logic        w_store;
  logic        w_report;
  logic [2:0]  w_err;

  mtm_alu_byte_rx u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .byte_valid (w_byte_valid),
    .byte_type  (w_byte_type),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  // CRC and opcode checks on the candidate control byte.
  always_comb begin
    w_crc_ok = (crc4_calc(r_shift[63:32], r_shift[31:0], w_byte_data[6:4]) == w_byte_data[3:0]);
    w_op_ok  = 1'b0;
    case (w_byte_data[6:4])
      AND, OR, ADD, SUB: w_op_ok = 1'b1;
      default:           w_op_ok = 1'b0;
    endcase
  end

  // Decide per received byte: store it, or report a command/error (DATA > CRC > OP).
  always_comb begin
    w_store  = 1'b0;
    w_report = 1'b0;
    w_err    = '0;
    if (w_frame_err) begin
      w_report = 1'b1;
      w_err    = ERR_DATA;
    end else if (w_byte_valid) begin
      if (w_byte_type == DATA) begin
        if (r_byte_cnt < 4'd8) begin
          w_store = 1'b1;
        end else begin
          w_report = 1'b1;
          w_err    = ERR_DATA;
        end
      end else if (r_byte_cnt != 4'd8) begin
        w_report = 1'b1;
        w_err    = ERR_DATA;
      end else begin
        w_report = 1'b1;
        if (!w_crc_ok)     w_err = ERR_CRC;
        else if (!w_op_ok) w_err = ERR_OP;
      end
    end
  end

  // Byte counter, operand assembly and registered command outputs.
  // Bytes are shifted in rather than written by index: the counter always
  // restarts at 0, so byte k ends up in slot k after eight shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_cmd_valid <= 1'b0;
      r_B         <= '0;
      r_A         <= '0;
      r_op        <= '0;
      r_err       <= '0;
    end else begin
      r_cmd_valid <= w_report;
      if (w_store) begin
        r_shift    <= {r_shift[55:0], w_byte_data};
        r_byte_cnt <= r_byte_cnt + 4'd1;
      end
      if (w_report) begin
        r_byte_cnt <= '0;
        r_err      <= w_err;
        if (w_err == ERR_DATA) begin
          r_B  <= '0;
          r_A  <= '0;
          r_op <= '0;
        end else begin
          r_B  <= r_shift[63:32];
          r_A  <= r_shift[31:0];
          r_op <= w_byte_data[6:4];
        end
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign B         = r_B;
  assign A         = r_A;
  assign op        = r_op;
  assign err_flags = r_err;

endmodule

// File: tb/tb_mtm_alu_cmd_deserializer.sv
// Bench for mtm_alu_cmd_deserializer: serial command stimulus with a scoreboard monitor.
module tb_mtm_alu_cmd_deserializer;
  import mtm_alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        sin;
  logic        cmd_valid;
  logic [31:0] B;
  logic [31:0] A;
  logic [2:0]  op;
  logic [2:0]  err_flags;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [2:0]  err;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] cyc     = '0;

  mtm_alu_cmd_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .cmd_valid (cmd_valid),
    .B         (B),
    .A         (A),
    .op        (op),
    .err_flags (err_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop);
    tick(1'b0);
    tick(t);
    for (int i = 7; i >= 0; i--) tick(d[i]);
    tick(stop);
  endtask

  task automatic send_data(input logic [31:0] b, input logic [31:0] a);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, b[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, a[i*8 +: 8], 1'b1);
  endtask

  // Called right after the frame whose stop bit triggers the report.
  task automatic expect_cmd(input logic [31:0] b, input logic [31:0] a,
                            input logic [2:0] o, input logic [2:0] e);
    exp_t x;
    x.b   = b;
    x.a   = a;
    x.op  = o;
    x.err = e;
    x.cyc = cyc;
    exp_q.push_back(x);
  endtask

  task automatic send_cmd(input logic [31:0] b, input logic [31:0] a,
                          input logic [7:0] ctl, input logic [2:0] e);
    send_data(b, a);
    send_frame(1'b1, ctl, 1'b1);
    expect_cmd(b, a, ctl[6:4], e);
  endtask

  // Monitor: every strobe must match the oldest expectation, one cycle after its stop bit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && cmd_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got B=%h A=%h op=%b err=%b, expected no strobe",
                   B, A, op, err_flags);
        end else begin
          e = exp_q.pop_front();
          check("B",       B, e.b);
          check("A",       A, e.a);
          check("op",      {29'b0, op}, {29'b0, e.op});
          check("err",     {29'b0, err_flags}, {29'b0, e.err});
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", {31'b0, cmd_valid}, 32'd0);
    check("rst_B",     B, 32'd0);
    check("rst_A",     A, 32'd0);
    check("rst_op",    {29'b0, op}, 32'd0);
    check("rst_err",   {29'b0, err_flags}, 32'd0);
    idle(2);

    // good ADD, then hold
    send_cmd(32'h0000_0002, 32'h0000_0003, 8'h46, 3'b000);
    idle(3);
    check("hold_B",   B, 32'h0000_0002);
    check("hold_op",  {29'b0, op}, 32'd4);
    check("hold_err", {29'b0, err_flags}, 32'd0);

    // bad CRC, invalid op
    send_cmd(32'h0000_0002, 32'h0000_0003, 8'h47, 3'b010);
    idle(1);
    send_cmd(32'h0000_0002, 32'h0000_0003, 8'h2C, 3'b001);
    idle(1);

    // further good commands: AND, OR, SUB, ADD with MSB-heavy operands
    send_cmd(32'h0000_0000, 32'h0000_0000, 8'h0B, 3'b000);
    idle(1);
    send_cmd(32'h0000_0000, 32'h0000_0000, 8'h18, 3'b000);
    idle(4);
    send_cmd(32'h8000_0000, 32'h0000_0001, 8'h5F, 3'b000);
    idle(1);
    send_cmd(32'h8000_0000, 32'h0000_0000, 8'h49, 3'b000);
    idle(2);

    // nine data bytes, then recovery
    send_data(32'h1122_3344, 32'h5566_7788);
    send_frame(1'b0, 8'h99, 1'b1);
    expect_cmd(32'd0, 32'd0, 3'd0, 3'b100);
    idle(2);
    send_cmd(32'h0000_0002, 32'h0000_0003, 8'h46, 3'b000);
    idle(2);

    // control byte after five data bytes, then recovery
    for (int i = 0; i < 5; i++) send_frame(1'b0, 8'hA5, 1'b1);
    send_frame(1'b1, 8'h46, 1'b1);
    expect_cmd(32'd0, 32'd0, 3'd0, 3'b100);
    idle(1);
    send_cmd(32'h0000_0000, 32'h0000_0000, 8'h0B, 3'b000);
    idle(2);

    // framing error in the third byte, then recovery
    send_frame(1'b0, 8'h01, 1'b1);
    send_frame(1'b0, 8'h02, 1'b1);
    send_frame(1'b0, 8'h03, 1'b0);
    expect_cmd(32'd0, 32'd0, 3'd0, 3'b100);
    idle(1);
    send_cmd(32'h0000_0002, 32'h0000_0003, 8'h46, 3'b000);
    idle(2);

    // reset in the middle of byte 4
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'hFF, 1'b1);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    rst = 1'b1;
    sin = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_rst_valid", {31'b0, cmd_valid}, 32'd0);
    check("mid_rst_B",     B, 32'd0);
    check("mid_rst_A",     A, 32'd0);
    check("mid_rst_op",    {29'b0, op}, 32'd0);
    check("mid_rst_err",   {29'b0, err_flags}, 32'd0);
    rst = 1'b0;
    idle(2);
    send_cmd(32'h8000_0000, 32'h0000_0001, 8'h5F, 3'b000);
    idle(1);

    // back-to-back commands, no idle bits
    send_cmd(32'h0000_0002, 32'h0000_0003, 8'h46, 3'b000);
    send_cmd(32'h0000_0000, 32'h0000_0000, 8'h0B, 3'b000);
    idle(10);

    check("pending_expectations", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
